// File: rtl/bus_master_if.sv
// ----------------------------------------------------------------------------
// bus_master_if
//
// Per-master bus interface. Converts a held core request into one bus
// transaction: raise bus_req, wait for bus_grnt, drive a single address-strobe
// cycle, then wait for slave ready (or give up after TIMEOUT wait cycles).
//
// Ports
//   clk          : clock, rising edge
//   rest         : asynchronous active-high reset
//   cpu_req      : access request, held until cpu_done
//   cpu_rw       : 1 = read, 0 = write
//   cpu_addr     : access word address
//   cpu_wr_data  : write data
//   cpu_rd_data  : read data, valid with cpu_done and held afterwards
//   cpu_done     : one-cycle completion pulse
//   cpu_err      : one-cycle timeout flag, coincident with cpu_done
//   cpu_busy     : high whenever a transaction is in progress
//   bus_req      : request to the arbiter
//   bus_grnt     : grant from the arbiter (sampled only while requesting)
//   bus_as       : address strobe, one cycle per transaction
//   bus_rw, bus_addr, bus_wr_data : transaction fields, zero when not owning
//   bus_rd_data  : slave read data
//   bus_rdy      : slave ready / acknowledge
// ----------------------------------------------------------------------------
module bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic              bus_req,
    input  logic              bus_grnt,
    output logic              bus_as,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACCESS,
        ST_WAIT
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                lat_rw_reg, lat_rw_next;
    logic [ADDR_W-1:0]   lat_addr_reg, lat_addr_next;
    logic [DATA_W-1:0]   lat_wdata_reg, lat_wdata_next;
    logic                bus_req_reg, bus_req_next;
    logic                bus_as_reg, bus_as_next;
    logic                bus_rw_reg, bus_rw_next;
    logic [ADDR_W-1:0]   bus_addr_reg, bus_addr_next;
    logic [DATA_W-1:0]   bus_wdata_reg, bus_wdata_next;
    logic [DATA_W-1:0]   rd_data_reg, rd_data_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic                finish;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            lat_rw_reg    <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            bus_req_reg   <= 1'b0;
            bus_as_reg    <= 1'b0;
            bus_rw_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            rd_data_reg   <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            lat_rw_reg    <= lat_rw_next;
            lat_addr_reg  <= lat_addr_next;
            lat_wdata_reg <= lat_wdata_next;
            bus_req_reg   <= bus_req_next;
            bus_as_reg    <= bus_as_next;
            bus_rw_reg    <= bus_rw_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            rd_data_reg   <= rd_data_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        lat_rw_next    = lat_rw_reg;
        lat_addr_next  = lat_addr_reg;
        lat_wdata_next = lat_wdata_reg;
        bus_req_next   = bus_req_reg;
        bus_as_next    = 1'b0;          // strobe only ever lasts one cycle
        bus_rw_next    = bus_rw_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        rd_data_next   = rd_data_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        finish         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // The done cycle is skipped so the core can drop or change
                // its request before it is sampled again.
                if (cpu_req && !done_reg) begin
                    lat_rw_next    = cpu_rw;
                    lat_addr_next  = cpu_addr;
                    lat_wdata_next = cpu_wr_data;
                    bus_req_next   = 1'b1;
                    cnt_next       = '0;
                    state_next     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_grnt) begin
                    bus_as_next    = 1'b1;
                    bus_rw_next    = lat_rw_reg;
                    bus_addr_next  = lat_addr_reg;
                    bus_wdata_next = lat_wdata_reg;
                    state_next     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Ready takes priority over a coincident timeout.
                if (bus_rdy) begin
                    finish = 1'b1;
                    if (lat_rw_reg) begin
                        rd_data_next = bus_rd_data;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    finish   = 1'b1;
                    err_next = 1'b1;
                    if (lat_rw_reg) begin
                        rd_data_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Common exit: release the bus on the same edge done rises so the
        // arbiter can re-grant on the next edge.
        if (finish) begin
            done_next      = 1'b1;
            bus_req_next   = 1'b0;
            bus_rw_next    = 1'b0;
            bus_addr_next  = '0;
            bus_wdata_next = '0;
            state_next     = ST_IDLE;
        end
    end

    assign cpu_busy    = (state_reg != ST_IDLE);
    assign cpu_rd_data = rd_data_reg;
    assign cpu_done    = done_reg;
    assign cpu_err     = err_reg;
    assign bus_req     = bus_req_reg;
    assign bus_as      = bus_as_reg;
    assign bus_rw      = bus_rw_reg;
    assign bus_addr    = bus_addr_reg;
    assign bus_wr_data = bus_wdata_reg;

endmodule

// File: tb/tb_bus_master_if.sv
// ----------------------------------------------------------------------------
// tb_bus_master_if
//
// Scoreboard bench for bus_master_if. The driver issues core requests and
// plays arbiter and slave on a timeline it computes itself; for every request
// it pushes the expected request edge, strobe edge/fields and completion
// (edge, error flag, read data) into queues. A monitor on the falling edge
// pops and compares whenever the DUT raises bus_req, bus_as or cpu_done.
// ----------------------------------------------------------------------------
module tb_bus_master_if;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rest;
    logic          cpu_req, cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wr_data;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_done, cpu_err, cpu_busy;
    logic          bus_req, bus_grnt, bus_as, bus_rw;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_rd_data;
    logic          bus_rdy;

    bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rest(rest),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .bus_req(bus_req), .bus_grnt(bus_grnt), .bus_as(bus_as),
        .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            edge_n;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } as_t;

    typedef struct {
        int            edge_n;
        logic          err;
        logic [DW-1:0] rd;
    } done_t;

    as_t   as_q[$];
    done_t done_q[$];
    int    req_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_txn  = 0;
    bit in_flight = 1'b0;
    as_t cur;
    logic [DW-1:0] model_rd = '0;   // what cpu_rd_data should hold

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core keeps cpu_req high but wiggles the other fields; the transaction
    // in flight must not notice.
    task automatic scramble();
        cpu_rw      = 1'($urandom);
        cpu_addr    = AW'($urandom);
        cpu_wr_data = $urandom;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        bit prev_req;
        as_t a;
        done_t d;
        int e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rest) begin
                prev_req = 1'b0;
            end else begin
                chk("busy_vs_req", 64'(cpu_busy), 64'(bus_req));
                if (bus_req && !prev_req) begin
                    if (req_q.size() == 0) chk("req_unexpected", 64'(bus_req), 64'(0));
                    else begin
                        e = req_q.pop_front();
                        chk("req_edge", 64'(cyc), 64'(e));
                    end
                end
                if (bus_as) begin
                    if (as_q.size() == 0) chk("as_unexpected", 64'(bus_as), 64'(0));
                    else begin
                        a = as_q.pop_front();
                        chk("as_edge", 64'(cyc), 64'(a.edge_n));
                        chk("as_rw", 64'(bus_rw), 64'(a.rw));
                        chk("as_addr", 64'(bus_addr), 64'(a.addr));
                        chk("as_wdata", 64'(bus_wr_data), 64'(a.wdata));
                        chk("as_req", 64'(bus_req), 64'(1));
                        cur = a;
                        in_flight = 1'b1;
                    end
                end else if (in_flight && !cpu_done) begin
                    chk("held_fields", {bus_rw, bus_addr, bus_wr_data}, {1'b0, cur.rw, cur.addr, cur.wdata});
                end
                if (!bus_req) begin
                    chk("idle_fields", {bus_as, bus_rw, bus_addr, bus_wr_data}, 64'(0));
                end
                if (cpu_done) begin
                    if (done_q.size() == 0) chk("done_unexpected", 64'(cpu_done), 64'(0));
                    else begin
                        d = done_q.pop_front();
                        chk("done_edge", 64'(cyc), 64'(d.edge_n));
                        chk("done_err", 64'(cpu_err), 64'(d.err));
                        chk("done_rd", 64'(cpu_rd_data), 64'(d.rd));
                        chk("done_release", 64'(bus_req), 64'(0));
                    end
                    in_flight = 1'b0;
                end else if (cpu_err) begin
                    chk("err_without_done", 64'(cpu_err), 64'(0));
                end
                prev_req = bus_req;
            end
        end
    end

    // ------------------------------------------------------------------
    // One transaction. gdelay = REQ cycles without grant, rdy_at = index of
    // the WAIT cycle carrying bus_rdy (>= TO means never), gap = idle cycles
    // with cpu_req low before the request.
    // ------------------------------------------------------------------
    task automatic do_txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int gdelay, input int rdy_at, input logic [DW-1:0] rdata,
                          input int gap);
        int    e0, wcyc;
        bit    to;
        as_t   a;
        done_t d;
        repeat (gap) begin
            cpu_req = 1'b0; scramble();
            bus_grnt = 1'($urandom); bus_rdy = 1'($urandom); bus_rd_data = $urandom;
            tick();
        end
        e0   = cyc + 1;
        to   = (rdy_at >= TO);
        wcyc = to ? TO : rdy_at + 1;
        if (rw) model_rd = to ? '0 : rdata;
        req_q.push_back(e0);
        a.edge_n = e0 + gdelay + 1; a.rw = rw; a.addr = addr; a.wdata = wd;
        as_q.push_back(a);
        d.edge_n = e0 + gdelay + 2 + wcyc; d.err = to; d.rd = model_rd;
        done_q.push_back(d);

        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wr_data = wd;
        bus_grnt = 1'($urandom); bus_rdy = 1'($urandom);
        tick();                                         // accepted
        for (int i = 0; i < gdelay; i++) begin
            scramble(); bus_grnt = 1'b0; bus_rdy = 1'($urandom);
            tick();
        end
        scramble(); bus_grnt = 1'b1; bus_rdy = 1'($urandom);
        tick();                                         // -> ACCESS
        scramble(); bus_grnt = 1'($urandom); bus_rdy = 1'($urandom);
        tick();                                         // -> WAIT
        for (int j = 0; j < wcyc; j++) begin
            scramble(); bus_grnt = 1'($urandom);
            bus_rdy = (j == rdy_at);
            bus_rd_data = (j == rdy_at) ? rdata : $urandom;
            tick();
        end
        // Done cycle: request still high, must be ignored.
        scramble(); bus_grnt = 1'($urandom); bus_rdy = 1'($urandom); bus_rd_data = $urandom;
        tick();
        n_txn++;
        $display("txn %0d: rw=%0d addr=0x%0h wdata=0x%0h gdelay=%0d rdy_at=%0d gap=%0d exp_err=%0d exp_rd=0x%0h",
                 n_txn, rw, addr, wd, gdelay, rdy_at, gap, to, model_rd);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    initial begin : driver
        rest = 1'b1;
        cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
        bus_grnt = 1'b0; bus_rd_data = '0; bus_rdy = 1'b0;
        tick(); tick();
        chk("rst_req", 64'(bus_req), 64'(0));
        chk("rst_busy", 64'(cpu_busy), 64'(0));
        chk("rst_done_err", {cpu_done, cpu_err}, 64'(0));
        chk("rst_rd", 64'(cpu_rd_data), 64'(0));
        chk("rst_fields", {bus_as, bus_rw, bus_addr, bus_wr_data}, 64'(0));
        rest = 1'b0;

        // Parked write, accepted on the first edge after reset release.
        do_txn(1'b0, 30'h100, 32'hDEADBEEF, 0, 0, 32'h0, 0);
        // Contended read, back-to-back with the previous request.
        do_txn(1'b1, 30'h2A0, 32'h0, 4, 2, 32'h12345678, 0);
        // Read timeout: data forced to 0.
        do_txn(1'b1, 30'h55, 32'h1111, 0, 99, 32'hFFFFFFFF, 1);
        // Ready on the last WAIT cycle beats the timeout.
        do_txn(1'b1, 30'h56, 32'h2222, 1, TO - 1, 32'hA5A5A5A5, 0);
        // Write timeout: read data keeps its previous value.
        do_txn(1'b0, 30'h57, 32'h3333, 2, 99, 32'h0, 0);

        // Asynchronous reset in the middle of WAIT.
        req_q.push_back(cyc + 1);
        begin
            as_t a;
            a.edge_n = cyc + 2; a.rw = 1'b1; a.addr = 30'h3FF; a.wdata = 32'h77;
            as_q.push_back(a);
        end
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 30'h3FF; cpu_wr_data = 32'h77;
        bus_grnt = 1'b1; bus_rdy = 1'b0;
        tick(); tick(); tick();
        bus_grnt = 1'b0;
        tick();                                     // first WAIT cycle done
        @(negedge clk);
        #2;
        rest = 1'b1;
        in_flight = 1'b0;
        model_rd = '0;
        #1;
        chk("arst_req", 64'(bus_req), 64'(0));
        chk("arst_busy", 64'(cpu_busy), 64'(0));
        chk("arst_as_fields", {bus_as, bus_rw, bus_addr, bus_wr_data}, 64'(0));
        chk("arst_done_err", {cpu_done, cpu_err}, 64'(0));
        chk("arst_rd", 64'(cpu_rd_data), 64'(0));
        cpu_req = 1'b0;
        tick();
        rest = 1'b0;
        do_txn(1'b1, 30'h123, 32'h0, 0, 0, 32'hCAFEF00D, 0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            do_txn(1'($urandom), AW'($urandom), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), $urandom,
                   int'($urandom_range(0, 2)));
        end

        cpu_req = 1'b0; bus_rdy = 1'b0;
        repeat (4) tick();
        chk("queues_drained", 64'(req_q.size() + as_q.size() + done_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
